// File: rtl/spi_pkg.sv
// Shared types for the SPI shift engine: FSM state encoding and edge-counter sizing.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_e;

    // Edge counter must hold 0..2*WIDTH.
    function automatic int spi_ecw(input int width);
        return $clog2(2 * width + 1);
    endfunction

endpackage

// File: rtl/spi_halfper_div.sv
// Half-period divider: load sets count and reload value, tick fires on reaching zero while enabled.
module spi_halfper_div #(
    parameter int DIVW = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [DIVW-1:0] load_val_i,
    input  logic            en_i,
    output logic            tick_o
);

    logic [DIVW-1:0] cnt_q, cnt_d;
    logic [DIVW-1:0] rel_q, rel_d;

    assign tick_o = en_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        rel_d = rel_q;
        if (load_i) begin
            cnt_d = load_val_i;
            rel_d = load_val_i;
        end else if (tick_o) begin
            cnt_d = rel_q;
        end else if (en_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            rel_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rel_q <= rel_d;
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master: one START shifts a WIDTH-bit word out on MOSI and in from the selected MISO,
// in any CPOL/CPHA mode, with programmable half-period and optional chip-select hold.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int NSS   = 3,
    parameter int WIDTH = 8,
    parameter int DIVW  = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] txd_i,
    input  logic [NSS-1:0]   sel_i,
    input  logic [DIVW-1:0]  div_i,
    input  logic             cpol_i,
    input  logic             cpha_i,
    input  logic             lsbf_i,
    input  logic             keep_i,
    input  logic [NSS-1:0]   miso_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] rxd_o,
    output logic             mosi_o,
    output logic             sck_o,
    output logic [NSS-1:0]   nss_o,
    output logic [1:0]       dbg_state_o
);

    localparam int ECW = spi_ecw(WIDTH);
    localparam logic [ECW-1:0] LAST_EDGE = ECW'(2 * WIDTH - 1);

    spi_state_e       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [NSS-1:0]   sel_q, sel_d;
    logic [NSS-1:0]   nss_q, nss_d;
    logic [ECW-1:0]   edge_q, edge_d;
    logic             cpol_q, cpol_d, cpha_q, cpha_d, lsbf_q, lsbf_d, keep_q, keep_d;
    logic             mosi_q, mosi_d, sck_q, sck_d, done_q, done_d;

    logic accept, tick, leading, miso_bit, tx_bit;

    assign accept   = start_i && (state_q == IDLE);
    assign miso_bit = |(miso_i & sel_q);
    assign leading  = ~edge_q[0];
    assign tx_bit   = lsbf_q ? sr_q[0] : sr_q[WIDTH-1];

    spi_halfper_div #(.DIVW(DIVW)) u_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (accept),
        .load_val_i (div_i),
        .en_i       (busy_o),
        .tick_o     (tick)
    );

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        sel_d   = sel_q;
        nss_d   = nss_q;
        edge_d  = edge_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        lsbf_d  = lsbf_q;
        keep_d  = keep_q;
        mosi_d  = mosi_q;
        sck_d   = sck_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    sr_d    = txd_i;
                    sel_d   = sel_i;
                    nss_d   = ~sel_i;
                    edge_d  = '0;
                    cpol_d  = cpol_i;
                    cpha_d  = cpha_i;
                    lsbf_d  = lsbf_i;
                    keep_d  = keep_i;
                    sck_d   = cpol_i;
                    if (!cpha_i) begin
                        mosi_d = lsbf_i ? txd_i[0] : txd_i[WIDTH-1];
                    end
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    sck_d  = ~sck_q;
                    edge_d = edge_q + 1'b1;
                    // Sampling edge: leading for CPHA=0, trailing for CPHA=1; the other edge drives.
                    if (leading ^ cpha_q) begin
                        sr_d = lsbf_q ? {miso_bit, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], miso_bit};
                    end else if (edge_q != LAST_EDGE) begin
                        mosi_d = tx_bit;
                    end
                    if (edge_q == LAST_EDGE) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (!keep_q) begin
                        nss_d = '1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sr_q    <= '0;
            sel_q   <= '0;
            nss_q   <= '1;
            edge_q  <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsbf_q  <= 1'b0;
            keep_q  <= 1'b0;
            mosi_q  <= 1'b0;
            sck_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            sel_q   <= sel_d;
            nss_q   <= nss_d;
            edge_q  <= edge_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            lsbf_q  <= lsbf_d;
            keep_q  <= keep_d;
            mosi_q  <= mosi_d;
            sck_q   <= sck_d;
            done_q  <= done_d;
        end
    end

    // The shift register doubles as the receive word once the last bit is in.
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign rxd_o       = sr_q;
    assign mosi_o      = mosi_q;
    assign sck_o       = sck_q;
    assign nss_o       = nss_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Randomised bench for spi_shift_engine: driver issues words, monitor checks each DONE against queued expectations.
module tb_spi_shift_engine;

    localparam int NSS  = 3;
    localparam int W    = 8;
    localparam int DIVW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [W-1:0]    txd;
    logic [NSS-1:0]  sel;
    logic [DIVW-1:0] div;
    logic            cpol, cpha, lsbf, keep;
    logic [NSS-1:0]  miso;
    logic            busy_o, done_o, mosi_o, sck_o;
    logic [W-1:0]    rxd_o;
    logic [NSS-1:0]  nss_o;
    logic [1:0]      dbg_state_o;

    // Slave model: each MISO is either MOSI looped back (optionally inverted) or a constant.
    logic            mmode;
    logic [NSS-1:0]  flip, cval;
    assign miso = mmode ? cval : ({NSS{mosi_o}} ^ flip);

    always #5 clk = ~clk;

    spi_shift_engine #(.NSS(NSS), .WIDTH(W), .DIVW(DIVW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .txd_i       (txd),
        .sel_i       (sel),
        .div_i       (div),
        .cpol_i      (cpol),
        .cpha_i      (cpha),
        .lsbf_i      (lsbf),
        .keep_i      (keep),
        .miso_i      (miso),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rxd_o       (rxd_o),
        .mosi_o      (mosi_o),
        .sck_o       (sck_o),
        .nss_o       (nss_o),
        .dbg_state_o (dbg_state_o)
    );

    typedef struct {
        logic [W-1:0]   txd;
        logic [NSS-1:0] sel;
        logic           cpol, cpha, lsbf, keep;
        int             h;
    } txn_t;

    logic [W-1:0] exp_q[$];
    txn_t         txn_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Reference: the selected device's bit stream, assembled in transmit order, forms the word.
    function automatic logic [W-1:0] model_rx(input logic [W-1:0] t, input logic [NSS-1:0] s,
                                              input logic mm, input logic [NSS-1:0] fl,
                                              input logic [NSS-1:0] cv);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NSS; i++) begin
            if (s[i]) r = mm ? {W{cv[i]}} : (t ^ {W{fl[i]}});
        end
        return r;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        check(!busy_o, "idle_wait", busy_o, 0);
    endtask

    task automatic do_xfer(input logic [W-1:0] t, input logic [NSS-1:0] s, input logic [DIVW-1:0] d,
                           input logic pol, input logic pha, input logic lf, input logic kp,
                           input logic mm, input logic [NSS-1:0] fl, input logic [NSS-1:0] cv);
        txn_t x;
        wait_idle();
        txd = t; sel = s; div = d; cpol = pol; cpha = pha; lsbf = lf; keep = kp;
        mmode = mm; flip = fl; cval = cv;
        start = 1'b1;
        x.txd = t; x.sel = s; x.cpol = pol; x.cpha = pha; x.lsbf = lf; x.keep = kp;
        x.h = int'(d) + 1;
        txn_q.push_back(x);
        exp_q.push_back(model_rx(t, s, mm, fl, cv));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // START while busy with different inputs; must be ignored entirely.
    task automatic junk_start(input int delay);
        repeat (delay) begin @(posedge clk); #1; end
        txd = 8'hFF; sel = 3'b100; div = 8'd7; cpol = ~cpol; cpha = ~cpha; lsbf = ~lsbf; keep = ~keep;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Monitor: follows each transfer from BUSY rise to DONE and checks it against the popped expectation.
    txn_t cur;
    bit   active = 0, prev_busy = 0, prev_sck = 0;
    bit   nss_bad, edge_bad, bits_bad;
    int   busy_cnt, edges, nbits;
    logic [W-1:0] e;
    logic expb;

    always @(negedge clk) begin
        if (rst) begin
            active = 0;
            prev_busy = 0;
        end else begin
            if (busy_o && !prev_busy) begin
                check(txn_q.size() != 0, "txn_available", txn_q.size(), 1);
                if (txn_q.size() != 0) begin
                    cur = txn_q.pop_front();
                    active = 1;
                    busy_cnt = 1; edges = 0; nbits = 0;
                    nss_bad = 0; edge_bad = 0; bits_bad = 0;
                    check(sck_o == cur.cpol, "sck_idle_start", sck_o, cur.cpol);
                    if (nss_o !== ~cur.sel) nss_bad = 1;
                end
            end else if (busy_o && active) begin
                busy_cnt++;
                if (nss_o !== ~cur.sel) nss_bad = 1;
                if (sck_o !== prev_sck) begin
                    edges++;
                    if (busy_cnt != (edges + 1) * cur.h + 1) edge_bad = 1;
                    if (cur.cpha ? (edges % 2 == 0) : (edges % 2 == 1)) begin
                        if (nbits < W) begin
                            expb = cur.lsbf ? cur.txd[nbits] : cur.txd[W-1-nbits];
                            if (mosi_o !== expb) bits_bad = 1;
                        end
                        nbits++;
                    end
                end
            end
            if (done_o) begin
                check(exp_q.size() != 0, "done_expected", exp_q.size(), 1);
                if (exp_q.size() != 0 && active) begin
                    e = exp_q.pop_front();
                    check(rxd_o == e, "rxd", rxd_o, e);
                    check(busy_cnt == (2 * W + 2) * cur.h, "busy_len", busy_cnt, (2 * W + 2) * cur.h);
                    check(edges == 2 * W, "sck_edges", edges, 2 * W);
                    check(!bits_bad && nbits == W, "mosi_bits", nbits, W);
                    check(!nss_bad, "nss_during_busy", nss_bad, 0);
                    check(!edge_bad, "edge_timing", edge_bad, 0);
                    check(nss_o == (cur.keep ? ~cur.sel : {NSS{1'b1}}), "nss_after", nss_o,
                          cur.keep ? ~cur.sel : {NSS{1'b1}});
                    check(sck_o == cur.cpol, "sck_idle_end", sck_o, cur.cpol);
                    check(!busy_o, "busy_at_done", busy_o, 0);
                end
                active = 0;
            end
            if (prev_busy && !busy_o) check(done_o, "done_at_busy_end", done_o, 1);
            prev_busy = busy_o;
        end
        prev_sck = sck_o;
    end

    // Chip-select continuity watcher for the KEEP burst.
    bit watch = 0, glitch = 0;
    always @(negedge clk) if (watch && nss_o[2]) glitch = 1;

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, gap, sidx;
        rst = 1'b1; start = 1'b0; txd = '0; sel = '0; div = '0;
        cpol = 0; cpha = 0; lsbf = 0; keep = 0; mmode = 0; flip = '0; cval = '0;
        repeat (3) @(posedge clk);
        #1;
        check(!busy_o, "reset_busy", busy_o, 0);
        check(!done_o, "reset_done", done_o, 0);
        check(rxd_o == '0, "reset_rxd", rxd_o, 0);
        check(!mosi_o && !sck_o, "reset_mosi_sck", {mosi_o, sck_o}, 0);
        check(nss_o == 3'b111, "reset_nss", nss_o, 3'b111);
        check(dbg_state_o == 2'd0, "reset_state", dbg_state_o, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Mode 0 loopback, DONE exactly at cycle 19.
        do_xfer(8'hA5, 3'b001, 8'd0, 0, 0, 0, 0, 0, 3'b000, 3'b000);
        cyc = 1;
        while (!done_o && cyc < 100) begin @(posedge clk); #1; cyc++; end
        check(cyc == 19, "done_cycle", cyc, 19);

        // Mode 3, DIV=3, MISO[1] tied high.
        do_xfer(8'h3C, 3'b010, 8'd3, 1, 1, 0, 0, 1, 3'b000, 3'b010);
        // LSB first, no device selected.
        do_xfer(8'h01, 3'b000, 8'd0, 0, 0, 1, 0, 0, 3'b000, 3'b000);

        // KEEP burst on device 2: three words back to back, chip select must stay low.
        wait_idle();
        do_xfer(8'hA5, 3'b100, 8'd0, 0, 0, 0, 1, 0, 3'b100, 3'b000);
        watch = 1; glitch = 0;
        do_xfer(8'h55, 3'b100, 8'd0, 0, 0, 0, 1, 0, 3'b000, 3'b000);
        do_xfer(8'hC3, 3'b100, 8'd0, 0, 1, 1, 0, 0, 3'b000, 3'b000);
        wait_idle();
        watch = 0;
        check(!glitch, "keep_nss_continuous", glitch, 0);
        check(nss_o == 3'b111, "keep_release_nss", nss_o, 3'b111);

        // Reset mid-transfer at cycle 7.
        do_xfer(8'h96, 3'b001, 8'd1, 1, 0, 0, 1, 0, 3'b000, 3'b000);
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check(!busy_o, "abort_busy", busy_o, 0);
        check(nss_o == 3'b111, "abort_nss", nss_o, 3'b111);
        check(!sck_o, "abort_sck", sck_o, 0);
        check(!done_o, "abort_done", done_o, 0);
        rst = 1'b0;
        exp_q.delete();
        txn_q.delete();
        repeat (40) begin @(posedge clk); #1; end

        // START while busy is ignored.
        do_xfer(8'h5A, 3'b001, 8'd1, 0, 0, 0, 0, 0, 3'b000, 3'b000);
        junk_start(3);

        // Randomised traffic.
        for (int k = 0; k < 30; k++) begin
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                wait_idle();
                repeat (gap) begin @(posedge clk); #1; end
            end
            sidx = $urandom_range(0, NSS);
            do_xfer(W'($urandom), (sidx == 0) ? 3'b000 : 3'(1 << (sidx - 1)), DIVW'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 3'($urandom), 3'($urandom));
            if ($urandom_range(0, 3) == 0) junk_start($urandom_range(0, 5));
        end

        // Largest divider.
        do_xfer(8'hE7, 3'b010, 8'hFF, 0, 1, 0, 0, 0, 3'b010, 3'b000);
        wait_idle();
        repeat (5) begin @(posedge clk); #1; end
        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
